// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default widths, stage states.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_TAG_W = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_t;

  // Encoded as {M.valid, S.valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } stage_state_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Request and response valid/ready channels of the ALU execute stage.
interface alu_req_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [TAG_W-1:0] in_tag;

  modport master (
    output in_valid, alu_control, src_a, src_b, in_tag,
    input  in_ready
  );
  modport slave (
    input  in_valid, alu_control, src_a, src_b, in_tag,
    output in_ready
  );
endinterface

interface alu_rsp_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;

  modport master (
    output out_valid, result, zero, out_tag, illegal,
    input  out_ready
  );
  modport slave (
    input  out_valid, result, zero, out_tag, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: {control, a, b} -> {result, zero, illegal}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  logic lt;
  assign lt = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    unique case (1'b1)
      ctrl_i == ALU_AND: result_o = a_i & b_i;
      ctrl_i == ALU_OR:  result_o = a_i | b_i;
      ctrl_i == ALU_ADD: result_o = a_i + b_i;
      ctrl_i == ALU_SUB: result_o = a_i - b_i;
      ctrl_i == ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, lt};
      default:           illegal_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a two-entry skid buffer.
// Optional ALU_EXEC_PERF_EN adds op_count / stall_count counters.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  alu_req_if.slave    req,
  alu_rsp_if.master   rsp
`ifdef ALU_EXEC_PERF_EN
  ,
  output logic [31:0] op_count,
  output logic [31:0] stall_count
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  stage_state_e state_q, state_d;
  entry_t       m_q, m_d;
  entry_t       s_q, s_d;
  entry_t       core_e;
  logic         in_fire;
  logic         out_fire;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .ctrl_i   (req.alu_control),
    .a_i      (req.src_a),
    .b_i      (req.src_b),
    .result_o (core_e.res),
    .zero_o   (core_e.zero),
    .illegal_o(core_e.ill)
  );
  assign core_e.tag = req.in_tag;

  assign in_fire  = req.in_valid & req.in_ready;
  assign out_fire = rsp.out_valid & rsp.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_FULL1;
          m_d     = core_e;
        end
      end
      ST_FULL1: begin
        if (in_fire && out_fire) begin
          m_d = core_e;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire) begin
          state_d = ST_FULL2;
          s_d     = core_e;
        end
      end
      ST_FULL2: begin
        if (out_fire) begin
          state_d = ST_FULL1;
          m_d     = s_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // in_ready depends only on state and reset, never on out_ready
  always_comb begin
    req.in_ready  = (state_q != ST_FULL2) && !rst;
    rsp.out_valid = (state_q != ST_EMPTY);
    rsp.result    = m_q.res;
    rsp.zero      = m_q.zero;
    rsp.out_tag   = m_q.tag;
    rsp.illegal   = m_q.ill;
  end

`ifdef ALU_EXEC_PERF_EN
  logic [31:0] op_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_q + 32'(out_fire);
      stall_cnt_q <= stall_cnt_q
                   + 32'(rsp.out_valid & ~rsp.out_ready);
    end
  end

  assign op_count    = op_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed ops, back-pressure, reset.
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int T = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_req_if #(.WIDTH(W), .TAG_W(T)) req ();
  alu_rsp_if #(.WIDTH(W), .TAG_W(T)) rsp ();

`ifdef ALU_EXEC_PERF_EN
  logic [31:0] op_count;
  logic [31:0] stall_count;
`endif

  alu_exec_stage #(
    .WIDTH(W),
    .TAG_W(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .rsp (rsp)
`ifdef ALU_EXEC_PERF_EN
    ,
    .op_count   (op_count),
    .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic [T-1:0] tag;
    logic         ill;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  int   n_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [T-1:0] tg,
                      input logic [W-1:0] er, input logic ez,
                      input logic ei, input bit push);
    int n = 0;
    req.in_valid    = 1'b1;
    req.alu_control = c;
    req.src_a       = a;
    req.src_b       = b;
    req.in_tag      = tg;
    @(negedge clk);
    while (!req.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req.in_ready) chk("accept_timeout", 64'(req.in_ready), 1);
    else if (push) sbq.push_back('{er, ez, tg, ei});
    @(posedge clk);
    #1;
    req.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk(nm, 64'(sbq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      n_out   = 0;
      n_stall = 0;
    end else if (rsp.out_valid) begin
      if (!rsp.out_ready) begin
        n_stall++;
      end else begin
        n_out++;
        if (sbq.size() == 0) begin
          chk("out_expected", 64'(sbq.size() != 0), 1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("result", 64'(rsp.result), 64'(e.res));
          chk("zero", 64'(rsp.zero), 64'(e.z));
          chk("out_tag", 64'(rsp.out_tag), 64'(e.tag));
          chk("illegal", 64'(rsp.illegal), 64'(e.ill));
        end
      end
    end
  end

  initial begin
    req.in_valid    = 1'b0;
    req.alu_control = '0;
    req.src_a       = '0;
    req.src_b       = '0;
    req.in_tag      = '0;
    rsp.out_ready   = 1'b1;

    #1;
    chk("rst_out_valid", 64'(rsp.out_valid), 0);
    chk("rst_in_ready", 64'(req.in_ready), 0);
    chk("rst_result", 64'(rsp.result), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(req.in_ready), 1);
    @(posedge clk);
    #1;

    send(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd0, 1'b1, 1'b0, 1);
    chk("lat_add", 64'(rsp.out_valid), 1);
    send(ALU_SLT, 32'h8000_0000, 32'd1, 5'd4, 32'd1, 1'b0, 1'b0, 1);
    send(ALU_SLT, 32'd5, 32'h8000_0000, 5'd5, 32'd0, 1'b1, 1'b0, 1);
    send(ALU_SUB, 32'd7, 32'd7, 5'd6, 32'd0, 1'b1, 1'b0, 1);
    send(ALU_SUB, 32'd3, 32'd5, 5'd8, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    send(ALU_AND, 32'hF0F0, 32'hFF00, 5'd9, 32'hF000, 1'b0, 1'b0, 1);
    send(ALU_OR, 32'hF0F0, 32'h0F00, 5'd10, 32'hFFF0, 1'b0, 1'b0, 1);
    send(4'b1010, 32'd12, 32'd34, 5'd7, 32'd0, 1'b1, 1'b1, 1);
    send(ALU_ADD, 32'd2, 32'd3, 5'd11, 32'd5, 1'b0, 1'b0, 1);

    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(ALU_ADD, W'(i), 32'd100, T'(i), W'(100 + i),
               1'b0, 1'b0, 1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 rsp.out_ready = 1'b0;
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(req.in_ready), 0);
          chk("bp_out_valid", 64'(rsp.out_valid), 1);
          chk("bp_tag_stable", 64'(rsp.out_tag), 2);
          chk("bp_res_stable", 64'(rsp.result), 102);
          @(posedge clk);
        end
        #1 rsp.out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    rsp.out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, 5'd20, 32'd2, 1'b0, 1'b0, 0);
    send(ALU_ADD, 32'd2, 32'd2, 5'd21, 32'd4, 1'b0, 1'b0, 0);
    @(negedge clk);
    chk("full2_in_ready", 64'(req.in_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(rsp.out_valid), 0);
    chk("arst_result", 64'(rsp.result), 0);
    chk("arst_tag", 64'(rsp.out_tag), 0);
    chk("arst_zero", 64'(rsp.zero), 0);
    chk("arst_illegal", 64'(rsp.illegal), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rsp.out_ready = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(req.in_ready), 1);
    chk("rel_out_valid", 64'(rsp.out_valid), 0);
    @(posedge clk);
    #1;
    send(ALU_ADD, 32'd10, 32'd20, 5'd9, 32'd30, 1'b0, 1'b0, 1);
    chk("rel_latency", 64'(rsp.out_valid), 1);
    drain("final_drain");

`ifdef ALU_EXEC_PERF_EN
    rsp.out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd0, 5'd1, 32'd1, 1'b0, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1 rsp.out_ready = 1'b1;
    drain("perf_drain");
    @(negedge clk);
    chk("op_count", 64'(op_count), 64'(n_out));
    chk("stall_count", 64'(stall_count), 64'(n_stall));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
